// File: rtl/axi_reg_arbiter_pkg.sv
// Shared types for the write/read register-port arbiter: FSM states, granted side, stats width.
package axi_reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STB,
    WAIT,
    ACK
  } state_e;

  typedef enum logic {
    SIDE_WR,
    SIDE_RD
  } side_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/axi_reg_arbiter_if.sv
// Bundle of channel front-end and register-block signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface axi_reg_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              iWREQ;
  logic [ADDR_W-1:0] iWADR;
  logic [DATA_W-1:0] iWDAT;
  logic              oWACK;
  logic              oWERR;
  logic              iRREQ;
  logic [ADDR_W-1:0] iRADR;
  logic              oRACK;
  logic [DATA_W-1:0] oRDAT;
  logic              oRERR;
  logic [ADDR_W-1:0] oPADR;
  logic [DATA_W-1:0] oPWDAT;
  logic              oPWRTE;
  logic              oPRDEN;
  logic [DATA_W-1:0] iPRDAT;
  logic              iPRDY;
  logic              iPERR;

  modport slave (
    input  iWREQ, iWADR, iWDAT, iRREQ, iRADR, iPRDAT, iPRDY, iPERR,
    output oWACK, oWERR, oRACK, oRDAT, oRERR, oPADR, oPWDAT, oPWRTE, oPRDEN
  );

  modport master (
    output iWREQ, iWADR, iWDAT, iRREQ, iRADR, iPRDAT, iPRDY, iPERR,
    input  oWACK, oWERR, oRACK, oRDAT, oRERR, oPADR, oPWDAT, oPWRTE, oPRDEN
  );

endinterface

// File: rtl/axi_reg_arbiter_timeout_cnt.sv
// Wait timer for one register access; expired flags the last allowed cycle without a ready.
module arb_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge iCLK) begin
    if (iRST || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/axi_reg_arbiter.sv
// Round-robin arbiter sharing the register-block port between the AXI write and read channels.
// Optional ARB_STATS_EN adds saturating grant/timeout counters oWCNT, oRCNT, oTOCNT.
module axi_reg_arbiter
  import axi_reg_arb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter bit WR_FIRST    = 1'b1,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic iCLK,
  input  logic iRST,
  axi_reg_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [STATS_W-1:0] oWCNT,
  output logic [STATS_W-1:0] oRCNT,
  output logic [STATS_W-1:0] oTOCNT
`endif
);

  state_e            state;
  state_e            nextState;
  side_e             grantSide;
  side_e             pickSide;
  side_e             lastWinner;
  logic [ADDR_W-1:0] latAdr;
  logic [DATA_W-1:0] latWdat;
  logic [DATA_W-1:0] rdatReg;
  logic              errReg;
  logic              accessActive;
  logic              tmrExpired;
  logic              prdySeen;

  assign accessActive = (state == STB) || (state == WAIT);
  assign prdySeen     = accessActive && bus.iPRDY;

  arb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uTimer (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .clear  (!accessActive),
    .enable (accessActive && !bus.iPRDY),
    .expired(tmrExpired)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // On a tie the side that lost last time is granted.
  always_comb begin
    nextState = state;
    pickSide  = SIDE_WR;
    case (state)
      IDLE: begin
        if (bus.iWREQ && bus.iRREQ) begin
          pickSide  = (lastWinner == SIDE_WR) ? SIDE_RD : SIDE_WR;
          nextState = STB;
        end else if (bus.iWREQ) begin
          pickSide  = SIDE_WR;
          nextState = STB;
        end else if (bus.iRREQ) begin
          pickSide  = SIDE_RD;
          nextState = STB;
        end
      end
      STB:     nextState = bus.iPRDY ? ACK : WAIT;
      WAIT:    if (bus.iPRDY || tmrExpired) nextState = ACK;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A ready in the final wait cycle wins over the timeout.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      grantSide  <= SIDE_WR;
      lastWinner <= WR_FIRST ? SIDE_RD : SIDE_WR;
      latAdr     <= '0;
      latWdat    <= '0;
      rdatReg    <= '0;
      errReg     <= 1'b0;
    end else begin
      if (state == IDLE && nextState == STB) begin
        grantSide <= pickSide;
        latAdr    <= (pickSide == SIDE_WR) ? bus.iWADR : bus.iRADR;
        latWdat   <= (pickSide == SIDE_WR) ? bus.iWDAT : '0;
      end
      if (prdySeen) begin
        errReg <= bus.iPERR;
        if (grantSide == SIDE_RD) rdatReg <= bus.iPRDAT;
      end else if (state == WAIT && tmrExpired) begin
        errReg <= 1'b1;
      end
      if (state == ACK) lastWinner <= grantSide;
    end
  end

  assign bus.oPADR  = accessActive ? latAdr : '0;
  assign bus.oPWDAT = accessActive ? latWdat : '0;
  assign bus.oPWRTE = (state == STB) && (grantSide == SIDE_WR);
  assign bus.oPRDEN = (state == STB) && (grantSide == SIDE_RD);
  assign bus.oWACK  = (state == ACK) && (grantSide == SIDE_WR);
  assign bus.oWERR  = bus.oWACK && errReg;
  assign bus.oRACK  = (state == ACK) && (grantSide == SIDE_RD);
  assign bus.oRERR  = bus.oRACK && errReg;
  assign bus.oRDAT  = rdatReg;

`ifdef ARB_STATS_EN
  logic toFlag;

  // Counters saturate instead of wrapping so software sees "at least this many".
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      toFlag <= 1'b0;
      oWCNT  <= '0;
      oRCNT  <= '0;
      oTOCNT <= '0;
    end else begin
      if (prdySeen) begin
        toFlag <= 1'b0;
      end else if (state == WAIT && tmrExpired) begin
        toFlag <= 1'b1;
      end
      if (state == ACK) begin
        if (grantSide == SIDE_WR && oWCNT != '1) oWCNT <= oWCNT + STATS_W'(1);
        if (grantSide == SIDE_RD && oRCNT != '1) oRCNT <= oRCNT + STATS_W'(1);
        if (toFlag && oTOCNT != '1) oTOCNT <= oTOCNT + STATS_W'(1);
      end
    end
  end
`endif

endmodule
